// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV64I-subset decode stage with 2-entry buffer and illegal counter
module decode_stage #(
    parameter int XLEN       = 64,
    parameter bit EN_WORDOPS = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_op,
    output logic [2:0]       out_alufunc,
    output logic             out_regwrite,
    output logic             out_memread,
    output logic             out_memwrite,
    output logic [1:0]       out_memsize,
    output logic             out_memunsigned,
    output logic [4:0]       out_ra1,
    output logic [4:0]       out_ra2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    localparam bit RV64    = (XLEN == 64);
    localparam bit WORDOPS = EN_WORDOPS && RV64;

    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    localparam logic [4:0] OP_UNKNOWN = 5'd0;
    localparam logic [4:0] OP_ADDI    = 5'd1;
    localparam logic [4:0] OP_XORI    = 5'd2;
    localparam logic [4:0] OP_ORI     = 5'd3;
    localparam logic [4:0] OP_ANDI    = 5'd4;
    localparam logic [4:0] OP_LUI     = 5'd5;
    localparam logic [4:0] OP_AUIPC   = 5'd6;
    localparam logic [4:0] OP_ADD     = 5'd7;
    localparam logic [4:0] OP_SUB     = 5'd8;
    localparam logic [4:0] OP_AND     = 5'd9;
    localparam logic [4:0] OP_OR      = 5'd10;
    localparam logic [4:0] OP_XOR     = 5'd11;
    localparam logic [4:0] OP_LOAD    = 5'd12;
    localparam logic [4:0] OP_STORE   = 5'd13;
    localparam logic [4:0] OP_ADDIW   = 5'd14;
    localparam logic [4:0] OP_ADDW    = 5'd15;
    localparam logic [4:0] OP_SUBW    = 5'd16;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    typedef struct packed {
        logic [4:0]      op;
        logic [2:0]      alufunc;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic [1:0]      memsize;
        logic            memunsigned;
        logic [4:0]      ra1;
        logic [4:0]      ra2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } bundle_t;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    bundle_t         dec;

    bundle_t         mem [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      count;
    logic [1:0]      count_nxt;
    logic            in_ready_q;
    logic            accept;
    logic            deliver;
    bundle_t         head;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    // Combinational decode of the incoming instruction; every field defaulted, illegal encodings scrubbed
    always_comb begin
        imm_i        = {XLEN{in_instr[31]}};
        imm_i[11:0]  = in_instr[31:20];
        imm_s        = {XLEN{in_instr[31]}};
        imm_s[11:0]  = {in_instr[31:25], in_instr[11:7]};
        imm_u        = {XLEN{in_instr[31]}};
        imm_u[31:0]  = {in_instr[31:12], 12'b0};
        dec          = '0;
        dec.pc       = in_pc;
        case (opcode)
            OPC_OP_IMM: begin
                dec.ra1      = in_instr[19:15];
                dec.rd       = in_instr[11:7];
                dec.regwrite = 1'b1;
                dec.imm      = imm_i;
                case (f3)
                    3'b000:  begin dec.op = OP_ADDI; dec.alufunc = ALU_ADD; end
                    3'b100:  begin dec.op = OP_XORI; dec.alufunc = ALU_XOR; end
                    3'b110:  begin dec.op = OP_ORI;  dec.alufunc = ALU_OR;  end
                    3'b111:  begin dec.op = OP_ANDI; dec.alufunc = ALU_AND; end
                    default: dec.op = OP_UNKNOWN;
                endcase
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.op       = (opcode == OPC_LUI) ? OP_LUI : OP_AUIPC;
                dec.rd       = in_instr[11:7];
                dec.regwrite = 1'b1;
                dec.imm      = imm_u;
            end
            OPC_OP: begin
                dec.ra1      = in_instr[19:15];
                dec.ra2      = in_instr[24:20];
                dec.rd       = in_instr[11:7];
                dec.regwrite = 1'b1;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'b000:  begin dec.op = OP_ADD; dec.alufunc = ALU_ADD; end
                        3'b100:  begin dec.op = OP_XOR; dec.alufunc = ALU_XOR; end
                        3'b110:  begin dec.op = OP_OR;  dec.alufunc = ALU_OR;  end
                        3'b111:  begin dec.op = OP_AND; dec.alufunc = ALU_AND; end
                        default: dec.op = OP_UNKNOWN;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'b000) begin
                    dec.op      = OP_SUB;
                    dec.alufunc = ALU_SUB;
                end
            end
            OPC_LOAD: begin
                dec.ra1         = in_instr[19:15];
                dec.rd          = in_instr[11:7];
                dec.regwrite    = 1'b1;
                dec.memread     = 1'b1;
                dec.memsize     = f3[1:0];
                dec.memunsigned = f3[2];
                dec.imm         = imm_i;
                if (f3 == 3'd7 || (!RV64 && (f3 == 3'd3 || f3 == 3'd6)))
                    dec.op = OP_UNKNOWN;
                else
                    dec.op = OP_LOAD;
            end
            OPC_STORE: begin
                dec.ra1      = in_instr[19:15];
                dec.ra2      = in_instr[24:20];
                dec.memwrite = 1'b1;
                dec.memsize  = f3[1:0];
                dec.imm      = imm_s;
                if (f3[2] || (!RV64 && f3 == 3'd3))
                    dec.op = OP_UNKNOWN;
                else
                    dec.op = OP_STORE;
            end
            OPC_OP_IMM32: begin
                dec.ra1      = in_instr[19:15];
                dec.rd       = in_instr[11:7];
                dec.regwrite = 1'b1;
                dec.imm      = imm_i;
                if (WORDOPS && f3 == 3'b000)
                    dec.op = OP_ADDIW;
            end
            OPC_OP32: begin
                dec.ra1      = in_instr[19:15];
                dec.ra2      = in_instr[24:20];
                dec.rd       = in_instr[11:7];
                dec.regwrite = 1'b1;
                if (WORDOPS && f3 == 3'b000 && f7 == 7'h00) begin
                    dec.op = OP_ADDW;
                end else if (WORDOPS && f3 == 3'b000 && f7 == 7'h20) begin
                    dec.op      = OP_SUBW;
                    dec.alufunc = ALU_SUB;
                end
            end
            default: dec.op = OP_UNKNOWN;
        endcase
        if (dec.op == OP_UNKNOWN) begin
            dec         = '0;
            dec.pc      = in_pc;
            dec.illegal = 1'b1;
        end
    end

    assign accept    = in_valid && in_ready_q;
    assign out_valid = (count != 2'd0);
    assign deliver   = out_valid && out_ready;
    assign count_nxt = count + {1'b0, accept} - {1'b0, deliver};
    assign in_ready  = in_ready_q;
    assign head      = mem[rd_ptr];

    // Two-entry FIFO of decoded bundles; flush empties it and drops a same-cycle accept
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem[0]     <= '0;
            mem[1]     <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= ~wr_ptr;
            end
            if (deliver)
                rd_ptr <= ~rd_ptr;
            count      <= count_nxt;
            in_ready_q <= (count_nxt < 2'd2);
        end
    end

    // Saturating count of illegal bundles actually handed to execute
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            illegal_count <= '0;
        else if (!flush && deliver && head.illegal && (illegal_count != {CNT_W{1'b1}}))
            illegal_count <= illegal_count + 1'b1;
    end

    assign out_op          = head.op;
    assign out_alufunc     = head.alufunc;
    assign out_regwrite    = head.regwrite;
    assign out_memread     = head.memread;
    assign out_memwrite    = head.memwrite;
    assign out_memsize     = head.memsize;
    assign out_memunsigned = head.memunsigned;
    assign out_ra1         = head.ra1;
    assign out_ra2         = head.ra2;
    assign out_rd          = head.rd;
    assign out_imm         = head.imm;
    assign out_pc          = head.pc;
    assign out_illegal     = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_regwrite, a_memread, a_memwrite, a_memunsigned, a_illegal;
    logic [4:0]  a_op, a_ra1, a_ra2, a_rd;
    logic [2:0]  a_alufunc;
    logic [1:0]  a_memsize;
    logic [63:0] a_imm, a_pc;
    logic [31:0] a_count;

    logic        b_in_ready, b_out_valid, b_regwrite, b_memread, b_memwrite, b_memunsigned, b_illegal;
    logic [4:0]  b_op, b_ra1, b_ra2, b_rd;
    logic [2:0]  b_alufunc;
    logic [1:0]  b_memsize;
    logic [63:0] b_imm, b_pc;
    logic [1:0]  b_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(64), .EN_WORDOPS(1), .CNT_W(32)) u_dut (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_op(a_op), .out_alufunc(a_alufunc), .out_regwrite(a_regwrite), .out_memread(a_memread),
        .out_memwrite(a_memwrite), .out_memsize(a_memsize), .out_memunsigned(a_memunsigned),
        .out_ra1(a_ra1), .out_ra2(a_ra2), .out_rd(a_rd), .out_imm(a_imm), .out_pc(a_pc),
        .out_illegal(a_illegal), .illegal_count(a_count)
    );

    decode_stage #(.XLEN(64), .EN_WORDOPS(0), .CNT_W(2)) u_dut_nw (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_op(b_op), .out_alufunc(b_alufunc), .out_regwrite(b_regwrite), .out_memread(b_memread),
        .out_memwrite(b_memwrite), .out_memsize(b_memsize), .out_memunsigned(b_memunsigned),
        .out_ra1(b_ra1), .out_ra2(b_ra2), .out_rd(b_rd), .out_imm(b_imm), .out_pc(b_pc),
        .out_illegal(b_illegal), .illegal_count(b_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #3;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 64'h0; out_ready = 1'b0;
        #12;
        tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b exp 0", a_out_valid); end
        tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b exp 1", a_in_ready); end
        tests++; if (a_count !== 32'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", a_count); end
        tests++; if (a_op !== 5'd0 || a_imm !== 64'd0 || a_illegal !== 1'b0) begin fails++; $display("FAIL reset_payload op %0d imm %0h ill %0b exp 0", a_op, a_imm, a_illegal); end
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 64'h100;
        tick();
        tests++; if (a_out_valid !== 1'b1 || a_op !== 5'd1) begin fails++; $display("FAIL addi_valid_op got v%0b op%0d exp v1 op1", a_out_valid, a_op); end
        tests++; if (a_ra1 !== 5'd0 || a_rd !== 5'd1 || a_regwrite !== 1'b1) begin fails++; $display("FAIL addi_regs got ra1 %0d rd %0d rw %0b exp 0 1 1", a_ra1, a_rd, a_regwrite); end
        tests++; if (a_imm !== 64'd5 || a_pc !== 64'h100 || a_alufunc !== 3'd0) begin fails++; $display("FAIL addi_imm_pc got imm %0h pc %0h alu %0d exp 5 100 0", a_imm, a_pc, a_alufunc); end
        in_instr = 32'h402081B3; in_pc = 64'h104;
        tick();
        tests++; if (a_out_valid !== 1'b1 || a_op !== 5'd8 || a_alufunc !== 3'd1) begin fails++; $display("FAIL sub_op got v%0b op%0d alu%0d exp v1 op8 alu1", a_out_valid, a_op, a_alufunc); end
        tests++; if (a_ra1 !== 5'd1 || a_ra2 !== 5'd2 || a_rd !== 5'd3 || a_imm !== 64'd0) begin fails++; $display("FAIL sub_regs got %0d %0d %0d imm %0h exp 1 2 3 0", a_ra1, a_ra2, a_rd, a_imm); end
        in_valid = 1'b0;
        tick();
        tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %0b exp 0", a_out_valid); end
    endtask

    task automatic test_load_store();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00813283;
        tick();
        tests++; if (a_op !== 5'd12 || a_memread !== 1'b1 || a_memsize !== 2'd3 || a_memunsigned !== 1'b0) begin fails++; $display("FAIL load_ctl got op%0d mr%0b ms%0d mu%0b exp 12 1 3 0", a_op, a_memread, a_memsize, a_memunsigned); end
        tests++; if (a_imm !== 64'd8 || a_rd !== 5'd5 || a_ra1 !== 5'd2 || a_regwrite !== 1'b1) begin fails++; $display("FAIL load_fields got imm %0h rd %0d ra1 %0d rw %0b exp 8 5 2 1", a_imm, a_rd, a_ra1, a_regwrite); end
        in_instr = 32'h00513823;
        tick();
        tests++; if (a_op !== 5'd13 || a_memwrite !== 1'b1 || a_regwrite !== 1'b0 || a_memread !== 1'b0) begin fails++; $display("FAIL store_ctl got op%0d mw%0b rw%0b mr%0b exp 13 1 0 0", a_op, a_memwrite, a_regwrite, a_memread); end
        tests++; if (a_ra1 !== 5'd2 || a_ra2 !== 5'd5 || a_imm !== 64'd16 || a_rd !== 5'd0) begin fails++; $display("FAIL store_fields got %0d %0d imm %0h rd %0d exp 2 5 10 0", a_ra1, a_ra2, a_imm, a_rd); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h123450B7;
        tick();
        tests++; if (a_op !== 5'd5 || a_imm !== 64'h12345000 || a_rd !== 5'd1 || a_ra1 !== 5'd0) begin fails++; $display("FAIL lui_fields got op%0d imm %0h rd %0d ra1 %0d exp 5 12345000 1 0", a_op, a_imm, a_rd, a_ra1); end
        tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL stall_ready1 got %0b exp 1", a_in_ready); end
        in_instr = 32'h00500093;
        tick();
        tests++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL stall_full got %0b exp 0", a_in_ready); end
        in_valid = 1'b0;
        tick();
        tick();
        tests++; if (a_out_valid !== 1'b1 || a_op !== 5'd5 || a_imm !== 64'h12345000) begin fails++; $display("FAIL stall_hold got v%0b op%0d imm %0h exp 1 5 12345000", a_out_valid, a_op, a_imm); end
        out_ready = 1'b1;
        tick();
        tests++; if (a_op !== 5'd1 || a_imm !== 64'd5 || a_in_ready !== 1'b1) begin fails++; $display("FAIL stall_order got op%0d imm %0h rdy %0b exp 1 5 1", a_op, a_imm, a_in_ready); end
        tick();
        tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL stall_drain got %0b exp 0", a_out_valid); end
    endtask

    task automatic test_edge_encodings();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF00093;
        tick();
        tests++; if (a_imm !== 64'hFFFF_FFFF_FFFF_FFFF || a_op !== 5'd1) begin fails++; $display("FAIL addi_neg got imm %0h op %0d exp all-ones 1", a_imm, a_op); end
        in_instr = 32'hFFF0809B;
        tick();
        tests++; if (a_op !== 5'd14 || a_ra1 !== 5'd1 || a_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL addiw got op%0d ra1 %0d imm %0h exp 14 1 all-ones", a_op, a_ra1, a_imm); end
        tests++; if (b_illegal !== 1'b1 || b_op !== 5'd0 || b_ra1 !== 5'd0 || b_regwrite !== 1'b0) begin fails++; $display("FAIL addiw_nowordops got ill%0b op%0d ra1 %0d rw%0b exp 1 0 0 0", b_illegal, b_op, b_ra1, b_regwrite); end
        in_instr = 32'h4020C1B3;
        tick();
        tests++; if (a_illegal !== 1'b1 || a_op !== 5'd0 || a_rd !== 5'd0) begin fails++; $display("FAIL sub_f3_illegal got ill%0b op%0d rd%0d exp 1 0 0", a_illegal, a_op, a_rd); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFFFFFF;
        tick();
        tests++; if (a_illegal !== 1'b1 || a_op !== 5'd0 || b_illegal !== 1'b1) begin fails++; $display("FAIL ones_illegal got a%0b op%0d b%0b exp 1 0 1", a_illegal, a_op, b_illegal); end
        in_instr = 32'h003100BB;
        tick();
        tests++; if (a_op !== 5'd15 || a_illegal !== 1'b0 || a_ra1 !== 5'd2 || a_ra2 !== 5'd3 || a_rd !== 5'd1) begin fails++; $display("FAIL addw got op%0d ill%0b %0d %0d %0d exp 15 0 2 3 1", a_op, a_illegal, a_ra1, a_ra2, a_rd); end
        tests++; if (b_illegal !== 1'b1 || b_op !== 5'd0) begin fails++; $display("FAIL addw_nowordops got ill%0b op%0d exp 1 0", b_illegal, b_op); end
        in_valid = 1'b0;
        tick();
        tests++; if (b_count !== 2'd2 || a_count !== 32'd1) begin fails++; $display("FAIL illegal_count got b%0d a%0d exp 2 1", b_count, a_count); end
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFFFFFFF;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        tests++; if (b_out_valid !== 1'b0) begin fails++; $display("FAIL flush_illegal_valid got %0b exp 0", b_out_valid); end
        out_ready = 1'b1;
        tick();
        tests++; if (b_count !== 2'd2 || a_count !== 32'd1) begin fails++; $display("FAIL flushed_not_counted got b%0d a%0d exp 2 1", b_count, a_count); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFFFFFFF;
        tick();
        tick();
        tests++; if (b_count !== 2'd3) begin fails++; $display("FAIL sat_reach got %0d exp 3", b_count); end
        in_valid = 1'b0;
        tick();
        tests++; if (b_count !== 2'd3 || a_count !== 32'd3) begin fails++; $display("FAIL sat_hold got b%0d a%0d exp 3 3", b_count, a_count); end
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093;
        tick();
        in_instr = 32'h402081B3;
        tick();
        tests++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL flush_pre_full got %0b exp 0", a_in_ready); end
        flush = 1'b1; in_instr = 32'h123450B7; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tests++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin fails++; $display("FAIL flush_full got v%0b rdy%0b exp 0 1", a_out_valid, a_in_ready); end
        tick();
        tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL flush_nothing_after got %0b exp 0", a_out_valid); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093;
        tick();
        in_instr = 32'h402081B3;
        tick();
        in_valid = 1'b0;
        tests++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin fails++; $display("FAIL midreset_pre got rdy%0b v%0b exp 0 1", a_in_ready, a_out_valid); end
        #2;
        resetn = 1'b0;
        #1;
        tests++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin fails++; $display("FAIL midreset_async got v%0b rdy%0b exp 0 1", a_out_valid, a_in_ready); end
        tests++; if (a_count !== 32'd0 || b_count !== 2'd0 || a_op !== 5'd0) begin fails++; $display("FAIL midreset_clear got a%0d b%0d op%0d exp 0 0 0", a_count, b_count, a_op); end
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_store();
        test_stall();
        test_edge_encodings();
        test_illegal();
        test_saturation();
        test_flush_full();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before completion");
        $fatal(1);
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV64I-subset instruction decode stage; sits between fetch and execute.
- Replaces the purely combinational decoder. Every control field is fully specified for every encoding.
- Adds immediate generation, rd extraction, illegal-instruction flagging and a saturating illegal-instruction counter.
- Parametrised for XLEN and optional RV64 word ops, with a valid/ready handshake, a 2-entry skid buffer and flush.

Parameters:
- XLEN, 64, datapath/PC/immediate width (32 or 64)
- EN_WORDOPS, 1, decode ADDIW/ADDW/SUBW; forced off when XLEN=32
- CNT_W, 32, illegal-counter width

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  discard all buffered and incoming instructions this cycle
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts the bundle
- out_op  out  5  op code: UNKNOWN=0 ADDI=1 XORI=2 ORI=3 ANDI=4 LUI=5 AUIPC=6 ADD=7 SUB=8 AND=9 OR=10 XOR=11 LOAD=12 STORE=13 ADDIW=14 ADDW=15 SUBW=16
- out_alufunc  out  3  ADD=0 SUB=1 AND=2 OR=3 XOR=4
- out_regwrite / out_memread / out_memwrite  out  1 each  control strobes
- out_memsize  out  2  instr[13:12] for LOAD/STORE, else 0
- out_memunsigned  out  1  instr[14] for LOAD, else 0
- out_ra1, out_ra2, out_rd  out  5 each  register addresses, 0 when unused
- out_imm  out  XLEN  sign-extended I/S/U immediate, 0 for R-type
- out_pc  out  XLEN  PC passthrough
- out_illegal  out  1  encoding not supported under the current parameters
- illegal_count  out  CNT_W  saturating count of illegal bundles delivered

Behaviour:
- Reset (resetn=0, asynchronous):
  - buffer emptied; out_valid=0, in_ready=1, illegal_count=0.
  - All payload outputs 0, with out_op=UNKNOWN.
- Decode is combinational on in_instr; the result is captured into the buffer on an accept (in_valid & in_ready).
- Output fields are fully assigned for every encoding. No latches; no field is left undriven on any path.
- Latency: an instruction accepted in cycle N is presented with out_valid=1 in cycle N+1.
- Buffer: 2 entries, FIFO order. in_ready = (occupancy<2), registered.
  - Accept and deliver in the same cycle: occupancy unchanged, sustains 1 instr/cycle.
  - Accept when occupancy=1 and out_ready=0: occupancy becomes 2, in_ready=0 next cycle.
- While out_valid=1 and out_ready=0, all out_* must hold stable.
- flush=1: occupancy becomes 0 at the next edge and an accept in the same cycle is discarded. out_valid=0 and in_ready=1 the next cycle. flush has priority over every other event.
- Illegal encodings (out_op=UNKNOWN, out_illegal=1, all strobes 0, ra1/ra2/rd=0):
  - any unlisted opcode/funct3/funct7
  - OP-type funct7 other than 0x00/0x20, or funct7=0x20 with funct3≠0
  - loads with funct3=7, or funct3=3/6 when XLEN=32
  - stores with funct3≥4, or funct3=3 when XLEN=32
  - OP-32/OP-IMM-32 when EN_WORDOPS=0
  - RV64 word ops when XLEN=32
- Register use:
  - R-type: ra1, ra2 and rd used.
  - I-type and LOAD: ra1 and rd.
  - STORE: ra1 and ra2; rd=0; regwrite=0; memwrite=1.
  - LUI/AUIPC: rd only, ra1=0.
  - LOAD: memread=1.
- ALU function:
  - alufunc=ADD for ADDI, ADDIW, ADDW, LUI, AUIPC, LOAD and STORE.
  - SUB/SUBW→SUB.
  - The logic ops map to AND/OR/XOR.
- illegal_count increments by 1 on each output handshake with out_illegal=1 and saturates at all-ones. Flushed illegal instructions are not counted.

Test Plan:
- Reset mid-stream with the buffer full → out_valid=0, in_ready=1, illegal_count=0 immediately (asynchronously).
- Back-to-back 0x00500093 then 0x402081B3 with out_ready=1 → cycle+1 ADDI: ra1=0, rd=1, imm=5, regwrite=1. Cycle+2 SUB: alufunc=1, ra1=1, ra2=2, rd=3.
- 0x00813283 then 0x00513823 →
  - LOAD: memread=1, memsize=3, imm=8, rd=5.
  - STORE: memwrite=1, ra1=2, ra2=5, imm=16, rd=0.
- 0x123450B7 sent with out_ready=0 for 3 cycles, second instruction queued → in_ready=0 after 2 accepts. Outputs hold LUI with imm=0x12345000. FIFO order preserved when out_ready rises.
- 0xFFFFFFFF, then 0x003100BB with EN_WORDOPS=0 → both out_illegal=1, illegal_count=2. A third illegal instruction flushed in-buffer leaves the count at 2.
- flush asserted together with in_valid=1 and occupancy=2 → next cycle out_valid=0, in_ready=1, nothing delivered.
